// File: rtl/spi_audio_rx_fifo.sv
// SPI slave receiver into a show-ahead FIFO; word lands in FIFO 3 clk after the sampling sclk edge reaches the pins.
// No backpressure to the SPI master: a word completing into a full FIFO with no read that cycle is dropped and flags overrun.
module spi_audio_rx_fifo #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int MSB_FIRST   = 1,
    parameter int SAMPLE_EDGE = 0
) (
    input  logic                          clk_25mhz,
    input  logic                          reset,
    input  logic                          com_sclk_in,
    input  logic                          com_mosi_in,
    input  logic                          com_active,
    input  logic                          rd_ready,
    input  logic                          clear_flags,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          data_ready,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          teste_mosi
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W);
    localparam logic [PW:0]   FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {IDLE, RECEIVING} state_t;

    logic [2:0]        sclk_q;
    logic [1:0]        mosi_q, act_q;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shifted;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              teste_q, teste_d;
    logic              word_done, frame_abort;
    logic              frame_on, sclk_edge, strobe, bit_in;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic              full, rd_fire, wr_fire, drop;
    logic              data_ready_q, overrun_q, frame_err_q;

    // mosi and com_active stop at stage 2 so they line up with the sclk edge seen between stages 2 and 3
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            sclk_q <= '0;
            mosi_q <= '0;
            act_q  <= 2'b11;
        end else begin
            sclk_q <= {sclk_q[1:0], com_sclk_in};
            mosi_q <= {mosi_q[0], com_mosi_in};
            act_q  <= {act_q[0], com_active};
        end
    end

    assign frame_on  = ~act_q[1];
    assign sclk_edge = (SAMPLE_EDGE != 0) ? (sclk_q[2] & ~sclk_q[1]) : (sclk_q[1] & ~sclk_q[2]);
    assign strobe    = sclk_edge & frame_on;
    assign bit_in    = mosi_q[1];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        teste_d     = teste_q;
        word_done   = 1'b0;
        frame_abort = 1'b0;
        shifted     = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], bit_in}
                                       : {bit_in, shift_q[DATA_W-1:1]};
        case (state_q)
            IDLE: begin
                if (frame_on) begin
                    state_d = RECEIVING;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            RECEIVING: begin
                if (!frame_on) begin
                    state_d     = IDLE;
                    frame_abort = (cnt_q != '0);
                end else if (strobe) begin
                    shift_d = shifted;
                    teste_d = bit_in;
                    if (cnt_q == LAST) begin
                        cnt_d     = '0;
                        word_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            teste_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            teste_q <= teste_d;
        end
    end

    // a read on the same edge frees the slot, so a full FIFO can still accept the word
    assign full    = (count_q == FULL);
    assign rd_fire = rd_valid & rd_ready;
    assign wr_fire = word_done & (~full | rd_fire);
    assign drop    = word_done & full & ~rd_fire;

    always_comb begin
        count_d = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (wr_fire) mem_q[wr_ptr_q] <= shifted;
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q      <= count_d;
            data_ready_q <= word_done;
            overrun_q    <= drop | (overrun_q & ~clear_flags);
            frame_err_q  <= frame_abort | (frame_err_q & ~clear_flags);
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign data_ready = data_ready_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign teste_mosi = teste_q;
endmodule

// File: tb/tb_spi_audio_rx_fifo.sv
// Directed bench: default-parameter DUT with a queue scoreboard, plus an LSB-first instance on the same serial lines.
module tb_spi_audio_rx_fifo;
    logic        clk, rst, sclk, mosi, act_n, rd_ready, rd_ready2, clr;
    logic        rd_valid, rd_valid2, data_ready, data_ready2, overrun, overrun2;
    logic        frame_err, frame_err2, teste, teste2;
    logic [15:0] rd_data, rd_data2;
    logic [3:0]  fifo_count, fifo_count2;

    int total = 0;
    int bad   = 0;
    int dr_cnt = 0;
    int dr_base;
    logic [15:0] exp_q[$];
    logic        exp_ovr = 1'b0;

    spi_audio_rx_fifo u_dut (
        .clk_25mhz(clk), .reset(rst), .com_sclk_in(sclk), .com_mosi_in(mosi),
        .com_active(act_n), .rd_ready(rd_ready), .clear_flags(clr),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(fifo_count),
        .data_ready(data_ready), .overrun(overrun), .frame_err(frame_err),
        .teste_mosi(teste)
    );

    spi_audio_rx_fifo #(.MSB_FIRST(0)) u_lsb (
        .clk_25mhz(clk), .reset(rst), .com_sclk_in(sclk), .com_mosi_in(mosi),
        .com_active(act_n), .rd_ready(rd_ready2), .clear_flags(clr),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .fifo_count(fifo_count2),
        .data_ready(data_ready2), .overrun(overrun2), .frame_err(frame_err2),
        .teste_mosi(teste2)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(negedge clk) if (data_ready === 1'b1) dr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit align_rd);
        @(negedge clk);
        sclk = 1'b0;
        mosi = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        if (align_rd) begin
            // the rising edge is written into the FIFO on the third posedge after this point
            @(negedge clk);
            @(negedge clk);
            check("aligned_rd_data", rd_data, exp_q.pop_front());
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input bit align_rd);
        for (int i = 15; i >= 0; i--) send_bit(w[i], align_rd && (i == 0));
        if (exp_q.size() < 8) exp_q.push_back(w);
        else exp_ovr = 1'b1;
    endtask

    task automatic read_one(input string tag);
        check({tag, "_valid"}, rd_valid, 1'b1);
        if (exp_q.size() == 0) check({tag, "_model_empty"}, exp_q.size(), 1);
        else check(tag, rd_data, exp_q.pop_front());
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge clk);
        act_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        act_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; act_n = 1'b1;
        rd_ready = 1'b0; rd_ready2 = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_fifo_count", fifo_count, 4'd0);
        check("rst_rd_data", rd_data, 16'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // bit order: 1 then fifteen 0s
        frame_start();
        dr_base = dr_cnt;
        send_word(16'h8000, 1'b0);
        check("msb_order_data", rd_data, 16'h8000);
        check("lsb_order_data", rd_data2, 16'h0001);
        check("lsb_order_valid", rd_valid2, 1'b1);
        check("bit_order_pulses", dr_cnt - dr_base, 1);
        check("teste_after_zero", teste, 1'b0);
        rd_ready2 = 1'b1;
        read_one("bit_order_read");
        rd_ready2 = 1'b0;

        // basic word
        dr_base = dr_cnt;
        send_word(16'hA5C3, 1'b0);
        check("basic_pulses", dr_cnt - dr_base, 1);
        check("basic_count", fifo_count, 4'd1);
        check("basic_teste", teste, 1'b1);
        check("basic_lsb_data", rd_data2, 16'hC3A5);
        read_one("basic_read");
        check("basic_empty", rd_valid, 1'b0);
        frame_end();

        // overrun
        frame_start();
        dr_base = dr_cnt;
        for (int k = 1; k <= 9; k++) send_word(16'(k), 1'b0);
        check("ovr_pulses", dr_cnt - dr_base, 9);
        check("ovr_count", fifo_count, 4'd8);
        check("ovr_flag", overrun, exp_ovr);
        for (int k = 1; k <= 8; k++) read_one("ovr_read");
        check("ovr_drained", rd_valid, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_ovr = 1'b0;
        check("ovr_cleared", overrun, exp_ovr);

        // full FIFO, ninth word coincides with a read
        for (int k = 1; k <= 8; k++) send_word(16'h0010 + 16'(k), 1'b0);
        check("full_count", fifo_count, 4'd8);
        dr_base = dr_cnt;
        send_word(16'h0019, 1'b1);
        check("simul_pulse", dr_cnt - dr_base, 1);
        check("simul_count", fifo_count, 4'd8);
        check("simul_overrun", overrun, exp_ovr);
        for (int k = 1; k <= 8; k++) read_one("simul_read");
        check("simul_drained", fifo_count, 4'd0);
        frame_end();

        // partial frame
        frame_start();
        dr_base = dr_cnt;
        for (int k = 0; k < 7; k++) send_bit(1'b1, 1'b0);
        frame_end();
        check("partial_pulses", dr_cnt - dr_base, 0);
        check("partial_count", fifo_count, 4'd0);
        check("partial_frame_err", frame_err, 1'b1);
        frame_start();
        send_word(16'h1234, 1'b0);
        read_one("after_partial_read");
        frame_end();

        // reset mid-frame with words stored
        frame_start();
        for (int k = 1; k <= 3; k++) send_word(16'h0A00 + 16'(k), 1'b0);
        for (int k = 0; k < 10; k++) send_bit(1'b1, 1'b0);
        check("pre_rst_count", fifo_count, 4'd3);
        @(negedge clk);
        #5 rst = 1'b1;
        #1;
        check("mid_rst_valid", rd_valid, 1'b0);
        check("mid_rst_data", rd_data, 16'h0);
        check("mid_rst_count", fifo_count, 4'd0);
        check("mid_rst_ready", data_ready, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_frame_err", frame_err, 1'b0);
        check("mid_rst_teste", teste, 1'b0);
        exp_q.delete();
        exp_ovr = 1'b0;
        act_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_count", fifo_count, 4'd0);
        frame_start();
        dr_base = dr_cnt;
        send_word(16'h5A5A, 1'b0);
        check("post_rst_pulses", dr_cnt - dr_base, 1);
        check("post_rst_word_count", fifo_count, 4'd1);
        read_one("post_rst_read");
        frame_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_audio_rx_fifo.md
SPI_AUDIO_RX_FIFO -- requirements
Module: spi_audio_rx_fifo

Interface
REQ-001 Parameter DATA_W, default 16, word length in bits, range 8..32.
REQ-002 Parameter FIFO_DEPTH, default 8, receive FIFO entries, power of two, range 2..64.
REQ-003 Parameter MSB_FIRST, default 1; 1 = first received bit lands in bit DATA_W-1, 0 = first bit lands in bit 0.
REQ-004 Parameter SAMPLE_EDGE, default 0; 0 = sample com_mosi_in on sclk rising edge, 1 = on falling edge.
REQ-005 clk_25mhz  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 com_sclk_in  input  1  serial clock from the Pico, asynchronous to clk_25mhz.
REQ-008 com_mosi_in  input  1  serial data from the Pico, asynchronous.
REQ-009 com_active  input  1  frame enable, active-low: 0 = frame in progress, 1 = idle.
REQ-010 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-011 clear_flags  input  1  one-cycle pulse clearing the sticky error flags.
REQ-012 rd_valid  output  1  FIFO non-empty; rd_data holds the oldest word.
REQ-013 rd_data  output  DATA_W  oldest FIFO word (show-ahead).
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently stored.
REQ-015 data_ready  output  1  one-cycle pulse per completed word, whether stored or dropped.
REQ-016 overrun  output  1  sticky: a completed word was dropped because the FIFO was full.
REQ-017 frame_err  output  1  sticky: frame ended with a partial word.
REQ-018 teste_mosi  output  1  echo of the most recently sampled serial bit.

Function
REQ-019 com_sclk_in, com_mosi_in and com_active pass through two-flop synchronisers; a third sclk stage feeds edge detection; mosi and com_active use equal synchroniser depth, so data stays aligned to the detected edge.
REQ-020 The selected edge is detected as one clk_25mhz-cycle strobe; edges detected while synchronised com_active = 1 are ignored.
REQ-021 FSM states: IDLE, RECEIVING; IDLE -> RECEIVING when synchronised com_active = 0, clearing the shift register and bit counter; RECEIVING -> IDLE when synchronised com_active = 1.
REQ-022 In RECEIVING, each strobe shifts in one bit per MSB_FIRST and updates teste_mosi to that bit.
REQ-023 On the strobe carrying bit DATA_W-1 of a word, the assembled word is written to the FIFO on that clock edge and the bit counter wraps to 0; the FSM stays in RECEIVING for back-to-back words.
REQ-024 data_ready is high for exactly the one cycle after that write edge; rd_valid rises in the same cycle if the FIFO was empty.
REQ-025 A read occurs on each clock edge where rd_valid = 1 and rd_ready = 1; rd_ready while empty has no effect.
REQ-026 FIFO full and a word completes with no read that cycle: word dropped, FIFO unchanged, overrun set.
REQ-027 FIFO full and a word completes with a read that same cycle: the write is accepted, count stays FIFO_DEPTH, overrun not set.
REQ-028 Simultaneous read and write at any other fill level: count unchanged, FIFO order preserved.
REQ-029 RECEIVING -> IDLE with bit counter != 0: partial word discarded, no FIFO write, no data_ready pulse, frame_err set.
REQ-030 clear_flags clears overrun and frame_err; a set condition in the same cycle takes priority, so the flag stays 1.
REQ-031 fifo_count equals writes minus reads since reset, within 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-032 While reset = 1, regardless of the clock: state = IDLE; shift register, bit counter, pointers and fifo_count = 0; rd_valid, data_ready, overrun, frame_err and teste_mosi = 0; rd_data = 0.
REQ-033 Reset asserted mid-frame discards the partial word and all FIFO contents; after release, reception restarts only on a fresh com_active high-to-low sequence, with the counter at 0.

Verification
REQ-034 Defaults, com_active = 0, send 0xA5C3 MSB-first on rising edges -> one data_ready pulse, rd_valid = 1, rd_data = 0xA5C3, fifo_count = 1, teste_mosi = 1.
REQ-035 MSB_FIRST = 0, send bits 1,0,0,0 then twelve 0s -> rd_data = 0x0001.
REQ-036 rd_ready = 0, send 9 words 0x0001..0x0009 -> fifo_count = 8, overrun = 1, nine data_ready pulses; reads return 0x0001..0x0008; pulse clear_flags -> overrun = 0.
REQ-037 FIFO full, 9th word completes in the same cycle as rd_ready = 1 -> overrun stays 0, fifo_count stays 8, last read returns the 9th word.
REQ-038 com_active = 0, send 7 bits, set com_active = 1 -> no data_ready pulse, fifo_count = 0, frame_err = 1; the next full word is received correctly.
REQ-039 Assert reset after 10 bits with 3 words stored -> all outputs 0 immediately; after release, a new 16-bit frame yields exactly one correct word.
